// File: rtl/tl_a_beat_queue.sv
`default_nettype none
// ============================================================================
// Module      : tl_a_beat_queue
// Description : Two-entry registered TileLink A-channel buffer. Each dequeued
//               beat carries first/last burst markers.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_a_beat_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [2:0]        enq_opcode,
    input  logic [2:0]        enq_param,
    input  logic [2:0]        enq_size,
    input  logic [SRC_W-1:0]  enq_source,
    input  logic [ADDR_W-1:0] enq_address,
    input  logic [3:0]        enq_mask,
    input  logic [DATA_W-1:0] enq_data,

    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [2:0]        deq_opcode,
    output logic [2:0]        deq_param,
    output logic [2:0]        deq_size,
    output logic [SRC_W-1:0]  deq_source,
    output logic [ADDR_W-1:0] deq_address,
    output logic [3:0]        deq_mask,
    output logic [DATA_W-1:0] deq_data,
    output logic              deq_first,
    output logic              deq_last,
    output logic [1:0]        count
);

    localparam logic [1:0] c_FULL  = 2'd2;
    localparam logic [1:0] c_EMPTY = 2'd0;

    // Entry storage; deliberately not reset, the pointers and count define validity
    logic [2:0]        r_opcode_mem  [2];
    logic [2:0]        r_param_mem   [2];
    logic [2:0]        r_size_mem    [2];
    logic [SRC_W-1:0]  r_source_mem  [2];
    logic [ADDR_W-1:0] r_address_mem [2];
    logic [3:0]        r_mask_mem    [2];
    logic [DATA_W-1:0] r_data_mem    [2];

    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic [4:0]        r_beat_cnt;

    logic              w_enq_fire;
    logic              w_deq_fire;
    logic [4:0]        w_beats_m1;

    assign enq_ready  = (r_count != c_FULL) && !reset;
    assign deq_valid  = (r_count != c_EMPTY) && !reset;
    assign w_enq_fire = enq_valid && enq_ready;
    assign w_deq_fire = deq_valid && deq_ready;
    assign count      = r_count;

    always_ff @(posedge clock) begin
        if (w_enq_fire) begin
            r_opcode_mem[r_wptr]  <= enq_opcode;
            r_param_mem[r_wptr]   <= enq_param;
            r_size_mem[r_wptr]    <= enq_size;
            r_source_mem[r_wptr]  <= enq_source;
            r_address_mem[r_wptr] <= enq_address;
            r_mask_mem[r_wptr]    <= enq_mask;
            r_data_mem[r_wptr]    <= enq_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= c_EMPTY;
        end else begin
            if (w_enq_fire) begin
                r_wptr <= ~r_wptr;
            end
            if (w_deq_fire) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign deq_opcode  = r_opcode_mem[r_rptr];
    assign deq_param   = r_param_mem[r_rptr];
    assign deq_size    = r_size_mem[r_rptr];
    assign deq_source  = r_source_mem[r_rptr];
    assign deq_address = r_address_mem[r_rptr];
    assign deq_mask    = r_mask_mem[r_rptr];
    assign deq_data    = r_data_mem[r_rptr];

    // Data-carrying opcodes (0..3) span 2^(size-2) beats once size exceeds one beat
    always_comb begin
        w_beats_m1 = 5'd0;
        if (deq_opcode <= 3'd3) begin
            case (deq_size)
                3'd3:    w_beats_m1 = 5'd1;
                3'd4:    w_beats_m1 = 5'd3;
                3'd5:    w_beats_m1 = 5'd7;
                3'd6:    w_beats_m1 = 5'd15;
                3'd7:    w_beats_m1 = 5'd31;
                default: w_beats_m1 = 5'd0;
            endcase
        end
    end

    assign deq_first = (r_beat_cnt == 5'd0);
    assign deq_last  = (r_beat_cnt == w_beats_m1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_beat_cnt <= 5'd0;
        end else if (w_deq_fire) begin
            r_beat_cnt <= deq_last ? 5'd0 : r_beat_cnt + 5'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_a_beat_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_a_beat_queue
// Description : Randomized and directed bench for tl_a_beat_queue against a
//               transaction-level queue/message model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_a_beat_queue;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 4;

    typedef struct packed {
        logic [2:0]        op;
        logic [2:0]        param;
        logic [2:0]        size;
        logic [SRC_W-1:0]  src;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        mask;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [2:0]        enq_opcode = '0;
    logic [2:0]        enq_param = '0;
    logic [2:0]        enq_size = '0;
    logic [SRC_W-1:0]  enq_source = '0;
    logic [ADDR_W-1:0] enq_address = '0;
    logic [3:0]        enq_mask = '0;
    logic [DATA_W-1:0] enq_data = '0;
    logic              deq_valid;
    logic              deq_ready = 1'b0;
    logic [2:0]        deq_opcode;
    logic [2:0]        deq_param;
    logic [2:0]        deq_size;
    logic [SRC_W-1:0]  deq_source;
    logic [ADDR_W-1:0] deq_address;
    logic [3:0]        deq_mask;
    logic [DATA_W-1:0] deq_data;
    logic              deq_first;
    logic              deq_last;
    logic [1:0]        count;

    tl_a_beat_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_opcode(enq_opcode), .enq_param(enq_param), .enq_size(enq_size),
        .enq_source(enq_source), .enq_address(enq_address), .enq_mask(enq_mask),
        .enq_data(enq_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_opcode(deq_opcode), .deq_param(deq_param), .deq_size(deq_size),
        .deq_source(deq_source), .deq_address(deq_address), .deq_mask(deq_mask),
        .deq_data(deq_data), .deq_first(deq_first), .deq_last(deq_last),
        .count(count)
    );

    always #5 clock = ~clock;

    int    n_cmp = 0;
    int    n_err = 0;
    int    n_deq = 0;
    beat_t pend[$];     // beats the producer still has to offer
    beat_t mq[$];       // model of queue contents
    int    rem = 0;     // beats left in the message being dequeued, 0 = at a boundary

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [2:0] op, input logic [2:0] size);
        if (op <= 3'd3 && size >= 3'd3) return 1 << (size - 2);
        return 1;
    endfunction

    task automatic add_msg(input logic [2:0] op, input logic [2:0] size,
                           input logic [31:0] addr, input bit seq_data, input logic [31:0] dbase);
        beat_t b;
        int    n;
        n = beats_of(op, size);
        for (int i = 0; i < n; i++) begin
            b.op    = op;
            b.param = 3'($urandom_range(0, 7));
            b.size  = size;
            b.src   = SRC_W'($urandom);
            b.addr  = addr + 32'(i * 4);
            b.mask  = 4'($urandom);
            b.data  = seq_data ? dbase + 32'(i) : $urandom;
            pend.push_back(b);
        end
    endtask

    task automatic cycle(input bit ev_req, input bit dr);
        beat_t h;
        int    eff;
        bit    ef, df;
        @(negedge clock);
        check("enq_ready", 64'(enq_ready), 64'(mq.size() != 2));
        check("deq_valid", 64'(deq_valid), 64'(mq.size() != 0));
        check("count", 64'(count), 64'(mq.size()));
        check("deq_first", 64'(deq_first), 64'(rem == 0));
        if (mq.size() != 0) begin
            h   = mq[0];
            eff = (rem == 0) ? beats_of(h.op, h.size) : rem;
            check("deq_last", 64'(deq_last), 64'(eff == 1));
            check("deq_opcode", 64'(deq_opcode), 64'(h.op));
            check("deq_param", 64'(deq_param), 64'(h.param));
            check("deq_size", 64'(deq_size), 64'(h.size));
            check("deq_source", 64'(deq_source), 64'(h.src));
            check("deq_address", 64'(deq_address), 64'(h.addr));
            check("deq_mask", 64'(deq_mask), 64'(h.mask));
            check("deq_data", 64'(deq_data), 64'(h.data));
        end
        enq_valid = ev_req && (pend.size() != 0);
        if (enq_valid) begin
            h = pend[0];
        end else begin
            h = beat_t'({$urandom, $urandom, $urandom});
        end
        enq_opcode  = h.op;
        enq_param   = h.param;
        enq_size    = h.size;
        enq_source  = h.src;
        enq_address = h.addr;
        enq_mask    = h.mask;
        enq_data    = h.data;
        deq_ready   = dr;
        ef = enq_valid && (mq.size() != 2);
        df = dr && (mq.size() != 0);
        @(posedge clock);
        if (df) begin
            if (rem == 0) rem = beats_of(mq[0].op, mq[0].size);
            rem--;
            void'(mq.pop_front());
            n_deq++;
        end
        if (ef) mq.push_back(pend.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        check("rst_enq_ready", 64'(enq_ready), 64'd0);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        @(posedge clock);
        mq.delete();
        pend.delete();
        rem = 0;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int start;
        do_reset();

        // single Get
        add_msg(3'd4, 3'd2, 32'h8000_0000, 1'b0, 32'h0);
        repeat (3) cycle(1, 1);
        // 4-beat PutFull with sequential data
        add_msg(3'd0, 3'd4, 32'h1000, 1'b1, 32'hA0);
        repeat (7) cycle(1, 1);
        // back-pressure: fill while consumer stalls
        repeat (3) add_msg(3'd4, 3'd2, $urandom, 1'b0, 32'h0);
        repeat (3) cycle(1, 0);
        repeat (5) cycle(1, 1);
        // full queue with both sides active, then drain
        repeat (10) add_msg(3'd5, 3'd1, $urandom, 1'b0, 32'h0);
        repeat (2) cycle(1, 0);
        repeat (6) cycle(1, 1);
        repeat (4) cycle(0, 1);
        pend.delete();
        // reset in the middle of an 8-beat Put
        add_msg(3'd0, 3'd5, 32'h2000, 1'b1, 32'h50);
        start = n_deq;
        for (int k = 0; k < 20 && (n_deq - start) < 2; k++) cycle(1, 1);
        check("midburst_progress", 64'(n_deq - start), 64'd2);
        do_reset();
        add_msg(3'd4, 3'd2, 32'h3000, 1'b0, 32'h0);
        repeat (3) cycle(1, 1);
        // 32-beat PutPartial
        add_msg(3'd1, 3'd7, 32'h4000, 1'b1, 32'h100);
        repeat (36) cycle(1, 1);
        check("size7_done", 64'(rem), 64'd0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            if (pend.size() == 0)
                add_msg(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom, 1'b0, 32'h0);
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
